// File: rtl/audio_pkg.sv
// audio_pkg: sound identifiers, note table and priority helpers for the sound scheduler.
// Rev 1.0
`default_nettype none

package audio_pkg;

  typedef enum logic [2:0] {
    NONE   = 3'd0,
    WALL   = 3'd1,
    PADDLE = 3'd2,
    POINT  = 3'd3,
    LVLUP  = 3'd4,
    WIN    = 3'd5
  } sound_e;

  typedef struct packed {
    logic [16:0] half_period;
    logic [8:0]  dur_ms;
  } note_t;

  localparam int NOTES_PER_SOUND = 4;
  localparam int NUM_SOUNDS      = 5;

  localparam note_t NO_NOTE = '{17'd0, 9'd0};

  localparam note_t [1:5][0:3] SOUND_TABLE = '{
    '{'{17'd56818, 9'd30},  NO_NOTE,               NO_NOTE,               NO_NOTE},
    '{'{17'd28409, 9'd30},  NO_NOTE,               NO_NOTE,               NO_NOTE},
    '{'{17'd47801, 9'd100}, '{17'd63776, 9'd150},  NO_NOTE,               NO_NOTE},
    '{'{17'd47801, 9'd80},  '{17'd37936, 9'd80},   '{17'd31888, 9'd160},  NO_NOTE},
    '{'{17'd47801, 9'd120}, '{17'd37936, 9'd120},  '{17'd31888, 9'd120},  '{17'd23878, 9'd400}}
  };

  // Highest priority first.
  localparam sound_e PRIORITY_ORDER [0:4] = '{WIN, LVLUP, POINT, PADDLE, WALL};

  // Pending-register bit for a sound: bit (s-1).
  function automatic logic [4:0] sound_mask(input sound_e s);
    logic [4:0] m;
    m = '0;
    if (s != NONE && s <= WIN) m[3'(s) - 3'd1] = 1'b1;
    return m;
  endfunction

  function automatic sound_e pick_winner(input logic [4:0] pend);
    sound_e w;
    w = NONE;
    for (int i = NUM_SOUNDS - 1; i >= 0; i--) begin
      if ((pend & sound_mask(PRIORITY_ORDER[i])) != 5'd0) w = PRIORITY_ORDER[i];
    end
    return w;
  endfunction

  function automatic note_t note_lookup(input sound_e s, input logic [1:0] idx);
    note_t n;
    n = NO_NOTE;
    if (s != NONE && s <= WIN) n = SOUND_TABLE[3'(s)][idx];
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/audio_tick_gen.sv
// audio_tick_gen: restartable 1 ms strobe; first tick lands TICK_CYCLES cycles after restart.
// Rev 1.0
`default_nettype none

module audio_tick_gen #(
  parameter int TICK_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/sound_scheduler.sv
// sound_scheduler: latches sound events, picks the highest-priority one and plays its notes.
// Rev 1.0
`default_nettype none

module sound_scheduler
  import audio_pkg::*;
#(
  parameter int TICK_CYCLES = 50000,
  parameter int GAP_MS      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wall_hit,
  input  logic        paddle_hit,
  input  logic        point,
  input  logic        win,
  input  logic        lvl_up,
  input  logic        mute,
  output logic        tone_on,
  output logic [16:0] tone_half_period,
  output logic [2:0]  cur_sound,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam logic [8:0] GAP_LAST = 9'(GAP_MS - 1);

  state_t      state, state_nxt;
  sound_e      cur_q, cur_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [8:0]  ms_cnt, ms_nxt;
  logic [4:0]  pending, pending_nxt, set_mask, clr_mask;
  logic        win_seen;
  logic        tick, restart, preempt, has_next;
  sound_e      winner;
  note_t       note, next_note;

  audio_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  assign winner    = pick_winner(pending);
  assign note      = note_lookup(cur_q, idx);
  assign next_note = note_lookup(cur_q, idx + 2'd1);
  assign has_next  = (idx != 2'd3) && (next_note != NO_NOTE);
  assign set_mask  = mute ? 5'd0 : {win, lvl_up, point, paddle_hit, wall_hit};

  // WIN must have been pending for a full cycle before it aborts another sound.
  assign preempt = pending[4] && win_seen && !mute && (cur_q != WIN) &&
                   ((state == S_PLAY) || (state == S_GAP));

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur_q;
    idx_nxt   = idx;
    ms_nxt    = ms_cnt;
    clr_mask  = 5'd0;
    restart   = 1'b0;
    case (state)
      S_IDLE: begin
        if (pending != 5'd0 && !mute) begin
          state_nxt = S_LOAD;
          cur_nxt   = winner;
          clr_mask  = sound_mask(winner);
          idx_nxt   = 2'd0;
        end
      end
      S_LOAD: begin
        restart   = 1'b1;
        ms_nxt    = 9'd0;
        state_nxt = S_PLAY;
      end
      S_PLAY: begin
        if (tick) begin
          if (ms_cnt == note.dur_ms - 9'd1) begin
            ms_nxt    = 9'd0;
            state_nxt = S_GAP;
          end else begin
            ms_nxt = ms_cnt + 9'd1;
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (ms_cnt == GAP_LAST) begin
            ms_nxt = 9'd0;
            if (has_next) begin
              state_nxt = S_LOAD;
              idx_nxt   = idx + 2'd1;
            end else begin
              state_nxt = S_IDLE;
              cur_nxt   = NONE;
            end
          end else begin
            ms_nxt = ms_cnt + 9'd1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (preempt) begin
      state_nxt = S_LOAD;
      cur_nxt   = WIN;
      idx_nxt   = 2'd0;
      clr_mask  = sound_mask(WIN);
    end

    if (mute && state != S_IDLE) begin
      state_nxt = S_IDLE;
      cur_nxt   = NONE;
      clr_mask  = 5'd0;
    end

    pending_nxt = (pending & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      cur_q            <= NONE;
      idx              <= 2'd0;
      ms_cnt           <= 9'd0;
      pending          <= 5'd0;
      win_seen         <= 1'b0;
      tone_on          <= 1'b0;
      tone_half_period <= 17'd0;
      busy             <= 1'b0;
    end else begin
      state            <= state_nxt;
      cur_q            <= cur_nxt;
      idx              <= idx_nxt;
      ms_cnt           <= ms_nxt;
      pending          <= pending_nxt;
      win_seen         <= pending[4];
      tone_on          <= (state_nxt == S_PLAY);
      tone_half_period <= (state_nxt == S_PLAY) ? note.half_period : 17'd0;
      busy             <= (state_nxt != S_IDLE);
    end
  end

  assign cur_sound = cur_q;

endmodule

`default_nettype wire

// File: doc/sound_scheduler.md
# sound_scheduler

Arbitrates the game's sound events (wall_hit, paddle_hit, point, win, lvl_up) and sequences note playback for the audio path. It latches one pending request per event and selects the highest-priority request. It then steps through that sound's note table and drives a tone half-period, gated by tone_on, to the downstream tone generator and WM8731 DAC serializer.

## Interface
- TICK_CYCLES, default 50000: clk cycles per 1 ms tick at 50 MHz. Benches use 10.
- GAP_MS, default 2: silent gap after every note, in ticks.
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- wall_hit, paddle_hit, point, win, lvl_up  in  1 each  single-cycle event pulses.
- mute  in  1  level; aborts playback and blocks new events.
- tone_on  out  1  tone enable for the generator.
- tone_half_period  out  17  half-period in clk cycles; valid while tone_on=1, 0 otherwise.
- cur_sound  out  3  sound_e of the sound in progress; NONE when idle.
- busy  out  1  state != IDLE.

## Operation
- sound_e encoding: NONE=0, WALL=1, PADDLE=2, POINT=3, LVLUP=4, WIN=5.
- Priority: WIN > LVLUP > POINT > PADDLE > WALL.
- Pending register: 5 bits, one per sound.
  - An event pulse sets its bit.
  - Starting a sound clears its bit.
  - If set and clear hit the same bit in the same cycle, set wins.
  - There is no counting: N pulses for one sound produce one pending request.
- A pulse for the sound currently playing sets its pending bit, so that sound replays once afterwards.
- FSM states: IDLE, LOAD, PLAY, GAP.
  - IDLE: if any pending bit is set and mute=0, go to LOAD. Latch the winning sound into cur_sound, clear its bit, set note index to 0.
  - LOAD: tone_on=0. Fetch the table entry and restart the tick counter, then go to PLAY.
  - PLAY: tone_on=1 and tone_half_period=entry value for exactly dur_ms*TICK_CYCLES cycles, then go to GAP.
  - GAP: tone_on=0 for exactly GAP_MS*TICK_CYCLES cycles. Then:
    - if the next note exists (index<3 and its dur_ms != 0), go to LOAD with index+1;
    - otherwise go to IDLE and set cur_sound=NONE.
- Preemption: only WIN preempts.
  - If win's pending bit is set while in PLAY or GAP with cur_sound != WIN, the FSM goes to LOAD on the next edge.
  - cur_sound becomes WIN, the win bit is cleared, and the index resets to 0.
  - The aborted sound is dropped. Other pending bits are kept.
- mute=1:
  - Event pulses are not latched.
  - Any non-IDLE state goes to IDLE on the next edge; tone_on=0, cur_sound=NONE.
  - Existing pending bits are retained.
- Note table values (half-period in cycles @50 MHz / dur_ms):
  - WALL: 56818/30.
  - PADDLE: 28409/30.
  - POINT: 47801/100, 63776/150.
  - LVLUP: 47801/80, 37936/80, 31888/160.
  - WIN: 47801/120, 37936/120, 31888/120, 23878/400.
  - Unused entries are 0/0.

## Timing
- Reset values: all outputs 0 (tone_on, tone_half_period, cur_sound=NONE, busy). Pending register cleared, FSM in IDLE, index and counters 0.
- Reset mid-operation takes effect on the next edge with no residual pending requests.
- Start latency: a pulse sampled at edge 0 sets pending. Edge 1 enters LOAD (busy=1, cur_sound valid). Edge 2 enters PLAY (tone_on=1).
- Between notes, tone_on is low for GAP_MS*TICK_CYCLES + 1 cycles: the GAP duration plus one LOAD cycle.
- WIN preemption: win pulse sampled at edge 0, LOAD at edge 2, PLAY at edge 3.
- All outputs are registered. tone_half_period changes only on entry to PLAY and on leaving it.
- Width rules:
  - Tick counter: $clog2(TICK_CYCLES) bits.
  - ms counter: 9 bits (dur_ms ≤ 511).
  - Note index: 2 bits; it never wraps past 3.

## Structure
- audio_pkg:
  - sound_e enum (3 bits).
  - note_t struct {half_period[16:0], dur_ms[8:0]}.
  - NOTES_PER_SOUND=4.
  - SOUND_TABLE: constant note_t [1:5][0:3] holding the table above.
  - Priority order list.
- Sub-module audio_tick_gen:
  - Restartable 1 ms strobe generator (clk, reset, restart → tick).
  - Restart aligns the first tick to exactly TICK_CYCLES cycles later.
- sound_scheduler contains the pending register, priority encoder, FSM and ms counter.

## Test plan
All scenarios use TICK_CYCLES=10, GAP_MS=2.
- Reset, then wall_hit at edge 0 -> tone_on=1 from edge 2 with half_period 56818 for 300 cycles, then 20 low cycles; busy=0 and cur_sound=0 afterwards.
- paddle_hit and point pulsed in the same cycle -> POINT plays first (47801×1000, gap, 63776×1500, gap), then PADDLE plays 28409×300.
- win pulsed mid-PADDLE -> 1 cycle of tone_on=0 (LOAD), then 47801 with cur_sound=5; the full 4-note WIN sequence follows with no PADDLE remainder.
- Three wall_hit pulses during WALL playback -> exactly one replay, so tone_on rises exactly twice in total.
- mute asserted mid-LVLUP -> next edge tone_on=0, busy=0; lvl_up pulses during mute are ignored and nothing plays after mute drops.
- reset asserted during WIN with point pending -> next edge all outputs 0; nothing plays after reset releases.
